ofmap_collector: RTL and testbench

Output-side drain for the systolic TPU datapath. Takes the column-skewed `matrix_out` words from the PE array and de-skews them so each output vector is column-aligned. Stores each aligned vector in an internal register file and exposes a registered read port so the host can fetch results. It is the counterpart of the input buffer router and skew chains: those write and skew activations into the array, this block de-skews and buffers what comes out.

---
 rtl/tpu_pkg.sv | 22 ++
 rtl/delay_chain.sv | 38 +++
 rtl/ofmap_collector.sv | 175 +++++++++++++++++
 tb/tb_ofmap_collector.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the systolic TPU datapath.
//   outputSize        : width of one PE column result
//   nPEx              : number of PE columns per output vector
//   out_vec_t         : one column-aligned output vector (index x = column x)
//   collector_state_e : state encoding of the ofmap collector FSM
// ---------------------------------------------------------------------------
package tpu_pkg;

  localparam int outputSize = 24;
  localparam int nPEx       = 3;

  typedef logic [nPEx-1:0][outputSize-1:0] out_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collector_state_e;

endpackage

// File: rtl/delay_chain.sv
// ---------------------------------------------------------------------------
// delay_chain
// Fixed-length shift register: q is d delayed by nDelay clock cycles.
// All stages clear to zero on asynchronous active-low reset.
//   clk  : clock
//   nrst : asynchronous active-low reset
//   d    : input word   [dataSize-1:0]
//   q    : delayed word [dataSize-1:0]
// nDelay must be at least 1.
// ---------------------------------------------------------------------------
module delay_chain #(
  parameter int dataSize = 8,
  parameter int nDelay   = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [dataSize-1:0] d,
  output logic [dataSize-1:0] q
);

  logic [dataSize-1:0] r_stage [nDelay];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < nDelay; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < nDelay; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[nDelay-1];

endmodule

// File: rtl/ofmap_collector.sv
// ---------------------------------------------------------------------------
// ofmap_collector
// Output-side drain for the systolic array. De-skews the column-staggered
// PE results into aligned vectors, stores them in a register file and
// offers a registered read port to the host.
//   clk, nrst        : clock, asynchronous active-low reset
//   in_data          : skewed column results (column x lags column 0 by x)
//   in_valid         : column 0 of in_data is valid this cycle
//   cfg_num_vectors  : vectors to collect, sampled on ctrl_start
//   ctrl_start       : one-cycle pulse, starts (or restarts) a collection
//   rd_en, rd_addr   : read request and vector index
//   rd_data          : registered read data (1-cycle latency)
//   wr_count         : vectors counted in the current / last collection
//   flag_done        : one-cycle pulse when the collection completes
//   flag_overflow    : sticky, a vector arrived with the store full
//
// Read port semantics: there is no handshake. A request is accepted in every
// cycle rd_en is high; rd_data carries mem[rd_addr] from the following cycle
// and holds until the next accepted request. A same-cycle write to the same
// address is not forwarded, the old contents are returned.
// ---------------------------------------------------------------------------
module ofmap_collector #(
  parameter  int outputSize = 24,
  parameter  int nPEx       = 3,
  parameter  int numEntries = 64,
  localparam int numAddrOut = $clog2(numEntries)
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic [nPEx-1:0][outputSize-1:0]     in_data,
  input  logic                                in_valid,
  input  logic [numAddrOut:0]                 cfg_num_vectors,
  input  logic                                ctrl_start,
  input  logic                                rd_en,
  input  logic [numAddrOut-1:0]               rd_addr,
  output logic [nPEx-1:0][outputSize-1:0]     rd_data,
  output logic [numAddrOut:0]                 wr_count,
  output logic                                flag_done,
  output logic                                flag_overflow
);

  import tpu_pkg::*;

  localparam int DLY     = nPEx - 1;
  localparam int FLUSH_W = $clog2(nPEx) + 1;
  localparam logic [FLUSH_W-1:0]  FLUSH_LOAD = FLUSH_W'(DLY - 1);
  localparam logic [numAddrOut:0] ENTRIES    = (numAddrOut + 1)'(numEntries);

  collector_state_e                  r_state;
  logic [numAddrOut:0]               r_target;
  logic [numAddrOut:0]               r_wr_ptr;
  logic [numAddrOut:0]               r_wr_count;
  logic                              r_overflow;
  logic [FLUSH_W-1:0]                r_flush_cnt;
  logic [nPEx-1:0][outputSize-1:0]   r_rd_data;
  logic [nPEx-1:0][outputSize-1:0]   r_mem [numEntries];

  logic [nPEx-1:0][outputSize-1:0]   w_aligned;
  logic                              w_valid_d;
  logic                              w_valid_q;
  logic                              w_aligned_valid;
  logic                              w_accept;
  logic                              w_write;
  logic                              w_last;
  logic [numAddrOut:0]               w_count_inc;

  // Deskew: column x waits nPEx-1-x cycles so all columns line up with the
  // last one, which is already the latest and passes straight through.
  for (genvar x = 0; x < nPEx - 1; x++) begin : g_deskew
    delay_chain #(
      .dataSize (outputSize),
      .nDelay   (DLY - x)
    ) u_col_dly (
      .clk  (clk),
      .nrst (nrst),
      .d    (in_data[x]),
      .q    (w_aligned[x])
    );
  end
  assign w_aligned[nPEx-1] = in_data[nPEx-1];

  // Flushing the valid pipeline on start: the valid entering this cycle is
  // dropped at the input, and anything already inside the chain emerges
  // within the next nPEx-2 cycles, which the flush counter masks off. The
  // result is the same as clearing every stage of the chain.
  assign w_valid_d = in_valid & ~ctrl_start;

  delay_chain #(
    .dataSize (1),
    .nDelay   (DLY)
  ) u_valid_dly (
    .clk  (clk),
    .nrst (nrst),
    .d    (w_valid_d),
    .q    (w_valid_q)
  );

  assign w_aligned_valid = w_valid_q & (r_flush_cnt == '0);
  assign w_accept        = (r_state == ST_COLLECT) & w_aligned_valid & ~ctrl_start;
  assign w_write         = w_accept & (r_wr_ptr < ENTRIES);
  assign w_count_inc     = r_wr_count + 1'b1;
  assign w_last          = (w_count_inc == r_target);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_wr_ptr    <= '0;
      r_wr_count  <= '0;
      r_overflow  <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      if (r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - 1'b1;
      end
      if (ctrl_start) begin
        // Start from any state: re-latch config and clear all counters.
        r_target    <= cfg_num_vectors;
        r_wr_ptr    <= '0;
        r_wr_count  <= '0;
        r_overflow  <= 1'b0;
        r_flush_cnt <= FLUSH_LOAD;
        r_state     <= (cfg_num_vectors == '0) ? ST_DONE : ST_COLLECT;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_COLLECT: begin
            if (w_accept) begin
              // Overflowing vectors are still counted so the collection
              // terminates after the configured number of results.
              r_wr_count <= w_count_inc;
              if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
              if (w_last) begin
                r_state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Vector store: no reset, contents survive reset and restart.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr[numAddrOut-1:0]] <= w_aligned;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data       = r_rd_data;
  assign wr_count      = r_wr_count;
  assign flag_overflow = r_overflow;
  assign flag_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_ofmap_collector.sv
// ---------------------------------------------------------------------------
// tb_ofmap_collector
// Randomized bench for ofmap_collector (nPEx=3, numEntries=4). A reference
// model tracks what each collection should store, count and when it should
// finish; read and done expectations go into queues that a negedge monitor
// pops whenever the DUT presents read data or a done pulse.
// ---------------------------------------------------------------------------
module tb_ofmap_collector;
  import tpu_pkg::*;

  localparam int NPEX = 3;
  localparam int OSZ  = 24;
  localparam int NENT = 4;
  localparam int AW   = 2;
  localparam int VW   = NPEX * OSZ;

  // clock / reset
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  out_vec_t        in_data;
  logic            in_valid;
  logic [AW:0]     cfg_num_vectors;
  logic            ctrl_start;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  out_vec_t        rd_data;
  logic [AW:0]     wr_count;
  logic            flag_done;
  logic            flag_overflow;

  ofmap_collector #(
    .outputSize (OSZ),
    .nPEx       (NPEX),
    .numEntries (NENT)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .cfg_num_vectors (cfg_num_vectors),
    .ctrl_start      (ctrl_start),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .wr_count        (wr_count),
    .flag_done       (flag_done),
    .flag_overflow   (flag_overflow)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [VW-1:0] exp_q[$];
  int            done_q[$];
  out_vec_t      tx_q[$];

  // reference model: store contents and the running collection
  out_vec_t model_mem [NENT];
  bit       model_known [NENT];
  int       m_target;
  int       m_count;
  bit       m_active;

  logic rd_fire = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  // monitor
  always @(posedge clk) rd_fire <= rd_en & nrst;

  always @(negedge clk) begin
    if (nrst) begin
      if (rd_fire) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: got %h with no read outstanding", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
      if (flag_done) begin
        if (done_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL flag_done: pulse at cycle %0d, none expected", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  // model
  task automatic model_accept(input out_vec_t v, input int t);
    if (m_active && m_count < m_target) begin
      if (m_count < NENT) begin
        model_mem[m_count]   = v;
        model_known[m_count] = 1'b1;
      end
      m_count++;
      if (m_count == m_target) begin
        done_q.push_back(t + NPEX);
        m_active = 1'b0;
      end
    end
  endtask

  // drivers (all called at #1 after a rising edge)
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_collection(input int n);
    ctrl_start      = 1'b1;
    cfg_num_vectors = (AW + 1)'(n);
    m_target        = n;
    m_count         = 0;
    m_active        = (n != 0);
    if (n == 0) done_q.push_back(cyc + 1);
    wait_cycles(1);
    ctrl_start = 1'b0;
  endtask

  // Drives the vectors in tx_q with the array's skew: column x of vector k
  // appears in cycle k+x; idle column slots carry random junk.
  task automatic send_vectors(input int n, input bit counted);
    for (int c = 0; c < n + NPEX - 1; c++) begin
      in_valid = (c < n);
      for (int x = 0; x < NPEX; x++) begin
        if (c - x >= 0 && c - x < n) in_data[x] = tx_q[c-x][x];
        else                         in_data[x] = OSZ'($urandom);
      end
      if (c < n && counted) model_accept(tx_q[c], cyc);
      wait_cycles(1);
    end
    in_valid = 1'b0;
    tx_q.delete();
  endtask

  task automatic push_random(input int n);
    out_vec_t v;
    for (int k = 0; k < n; k++) begin
      for (int x = 0; x < NPEX; x++) v[x] = OSZ'($urandom);
      tx_q.push_back(v);
    end
  endtask

  task automatic issue_read(input int addr, input out_vec_t exp);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    exp_q.push_back(exp);
    wait_cycles(1);
    rd_en = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_wr_count"}, wr_count, m_count);
    check({tag, "_overflow"}, flag_overflow, (m_count > NENT));
  endtask

  task automatic read_all_known();
    for (int a = 0; a < NENT; a++) begin
      if (model_known[a]) issue_read(a, model_mem[a]);
    end
    wait_cycles(1);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    out_vec_t old_v;
    in_data         = '0;
    in_valid        = 1'b0;
    cfg_num_vectors = '0;
    ctrl_start      = 1'b0;
    rd_en           = 1'b0;
    rd_addr         = '0;
    m_target        = 0;
    m_count         = 0;
    m_active        = 1'b0;
    for (int a = 0; a < NENT; a++) model_known[a] = 1'b0;

    // reset state
    #12;
    check("reset_rd_data", rd_data, '0);
    check("reset_wr_count", wr_count, '0);
    check("reset_done", flag_done, 1'b0);
    check("reset_overflow", flag_overflow, 1'b0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    wait_cycles(2);

    // valid while idle: nothing counted, no done
    push_random(1);
    send_vectors(1, 1'b0);
    wait_cycles(3);
    check("idle_wr_count", wr_count, 0);

    // deskew of a single vector {10,20,30}
    start_collection(1);
    tx_q.push_back({24'd30, 24'd20, 24'd10});
    send_vectors(1, 1'b1);
    wait_cycles(3);
    check_status("deskew");
    issue_read(0, model_mem[0]);
    wait_cycles(2);

    // back-to-back vectors {k,k,k}
    start_collection(4);
    for (int k = 1; k <= 4; k++) tx_q.push_back({OSZ'(k), OSZ'(k), OSZ'(k)});
    send_vectors(4, 1'b1);
    wait_cycles(4);
    check_status("b2b");
    read_all_known();
    check("b2b_done_pending", done_q.size(), 0);

    // restart with a vector still in flight
    start_collection(2);
    push_random(1);
    fork
      send_vectors(1, 1'b0);
      begin
        wait_cycles(1);
        start_collection(1);
      end
    join
    check("restart_wr_count", wr_count, 0);
    push_random(1);
    send_vectors(1, 1'b1);
    wait_cycles(3);
    check_status("restart");
    issue_read(0, model_mem[0]);
    wait_cycles(1);

    // read-during-write at address 0
    start_collection(1);
    old_v = model_mem[0];
    tx_q.push_back({24'd9, 24'd8, 24'd7});
    fork
      send_vectors(1, 1'b1);
      begin
        wait_cycles(2);
        issue_read(0, old_v);
      end
    join
    wait_cycles(2);
    issue_read(0, model_mem[0]);
    check_status("rdw");
    wait_cycles(1);

    // overflow: 6 vectors into a 4-entry store
    start_collection(6);
    push_random(6);
    fork
      send_vectors(6, 1'b1);
      begin
        wait_cycles(6);
        check("ovf_before_5th", flag_overflow, 1'b0);
        wait_cycles(1);
        check("ovf_after_5th", flag_overflow, 1'b1);
      end
    join
    wait_cycles(4);
    check_status("overflow");
    read_all_known();

    // random readback
    for (int i = 0; i < 8; i++) begin
      int a;
      a = $urandom_range(0, NENT - 1);
      if (model_known[a]) issue_read(a, model_mem[a]);
    end
    wait_cycles(2);

    // asynchronous reset in the middle of an overflowing collection
    start_collection(6);
    push_random(5);
    send_vectors(5, 1'b1);
    wait_cycles(1);
    check_status("prereset");
    issue_read(1, model_mem[1]);
    wait_cycles(1);
    #3;
    nrst = 1'b0;
    #1;
    check("arst_rd_data", rd_data, '0);
    check("arst_wr_count", wr_count, '0);
    check("arst_done", flag_done, 1'b0);
    check("arst_overflow", flag_overflow, 1'b0);
    m_active = 1'b0;
    m_count  = 0;
    wait_cycles(2);
    nrst = 1'b1;
    wait_cycles(10);
    check("arst_done_pending", done_q.size(), 0);
    check_status("postreset");
    read_all_known();

    // drain outstanding reads
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_cycles(1);
    check("rd_pending", exp_q.size(), 0);
    check("done_pending", done_q.size(), 0);

    summary();
    $finish;
  end

endmodule
